fetch_unit: RTL

- Instruction-fetch stage directly upstream of the `mem` block in the sequential CPU.
- Owns the PC and drives `mem`'s address and read inputs. It captures the combinationally-read word on the next clk rising edge.
- Presents the word and its PC to the decode stage over a valid/ready handshake.
- Supports PC redirect (branch/jump) and flags misaligned redirect targets.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/pc_reg.sv | 27 ++
 rtl/fetch_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding, instruction size, bus widths.
package cpu_pkg;

   localparam int CPU_ADDR_W = 32;
   localparam int CPU_DATA_W = 32;
   localparam int INSN_BYTES = 4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2,
      ST_ERR  = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: async clear to RESET_PC, load has priority over +4 increment.
module pc_reg
   import cpu_pkg::*;
#(
   parameter int ADDR_W = CPU_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc
);

   // PC update; the add wraps naturally modulo 2^ADDR_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= load_val;
      end else if (inc) begin
         pc <= pc + ADDR_W'(INSN_BYTES);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads mem, hands words to decode.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | dead cycle after reset release, no memory access
// REQ     | mem_read asserted at pc, word captured on the next edge
// HOLD    | ins/ins_pc valid, waiting for ins_ready
// ERR     | misaligned redirect seen, halted until reset
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_W = CPU_ADDR_W,
   parameter int DATA_W = CPU_DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              ins_valid,
   input  logic              ins_ready,
   output logic [DATA_W-1:0] ins,
   output logic [ADDR_W-1:0] ins_pc,
   output logic              misalign
);

   fetch_state_t state_q, state_d;
   logic              pc_load, pc_inc, capture;
   logic [ADDR_W-1:0] pc;
   logic              target_ok;

   pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (pc_load),
      .load_val (redirect_pc),
      .inc      (pc_inc),
      .pc       (pc)
   );

   // Outputs decoded from state so reset drops them without waiting for clk.
   assign target_ok = (redirect_pc[1:0] == 2'b00);
   assign mem_addr  = pc;
   assign mem_write = 1'b0;
   assign mem_read  = (state_q == ST_REQ);
   assign ins_valid = (state_q == ST_HOLD);
   assign misalign  = (state_q == ST_ERR);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and PC control; a redirect overrides whatever the state wanted.
   always_comb begin
      state_d = state_q;
      pc_load = 1'b0;
      pc_inc  = 1'b0;
      capture = 1'b0;
      case (state_q)
         ST_IDLE: state_d = ST_REQ;
         ST_REQ: begin
            capture = 1'b1;
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (ins_ready) begin
               pc_inc  = 1'b1;
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_ERR;
      endcase
      if (redirect && (state_q != ST_ERR)) begin
         capture = 1'b0;
         pc_inc  = 1'b0;
         if (target_ok) begin
            pc_load = 1'b1;
            state_d = ST_REQ;
         end else begin
            state_d = ST_ERR;
         end
      end
   end

   // Captured instruction and its address; held until the next fetch completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ins    <= '0;
         ins_pc <= '0;
      end else if (capture) begin
         ins    <= mem_rdata;
         ins_pc <= pc;
      end
   end

endmodule
